// File: rtl/reg_access_seq_if.sv
// Request/response handshake plus the register-memory port of the operand sequencer.
// master: the sequencer's view; slave: the requester/memory side.
interface reg_access_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rd_a;
  logic              req_rd_b;
  logic              req_wr;
  logic [ADDR_W-1:0] req_sel_a;
  logic [ADDR_W-1:0] req_sel_b;
  logic [ADDR_W-1:0] req_sel_w;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_op_a;
  logic [DATA_W-1:0] rsp_op_b;

  logic [ADDR_W-1:0] mem_sel;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_write;
  logic              mem_enable;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  req_valid, req_rd_a, req_rd_b, req_wr, req_sel_a, req_sel_b, req_sel_w, req_wdata,
    output req_ready,
    output rsp_valid, rsp_op_a, rsp_op_b,
    input  rsp_ready,
    output mem_sel, mem_data_in, mem_read_write, mem_enable,
    input  mem_data_out
  );

  modport slave (
    output req_valid, req_rd_a, req_rd_b, req_wr, req_sel_a, req_sel_b, req_sel_w, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_op_a, rsp_op_b,
    output rsp_ready,
    input  mem_sel, mem_data_in, mem_read_write, mem_enable,
    output mem_data_out
  );
endinterface

// File: rtl/reg_access_seq.sv
// Operand-fetch/writeback sequencer for a single-port register memory with registered reads:
// up to two reads (A then B), an optional write, then a valid/ready response.
module reg_access_seq #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  reg_access_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, WR, RESP} state_t;

  typedef struct packed {
    logic              rd_a;
    logic              rd_b;
    logic              wr;
    logic [ADDR_W-1:0] sel_a;
    logic [ADDR_W-1:0] sel_b;
    logic [ADDR_W-1:0] sel_w;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, state_nx;
  req_t              rq, rq_nx;
  logic [DATA_W-1:0] op_a, op_b, op_a_nx, op_b_nx;
  logic              rsp_valid;
  logic              mem_enable, mem_rw;
  logic [ADDR_W-1:0] mem_sel;
  logic [DATA_W-1:0] mem_din;
  logic              en_nx, rw_nx;
  logic [ADDR_W-1:0] sel_nx;
  logic [DATA_W-1:0] din_nx;

  function automatic logic is_zero(input logic [ADDR_W-1:0] s);
    return ZERO_REG && (s == '0);
  endfunction

  // Register 0 reads as zero regardless of what the memory returns.
  function automatic logic [DATA_W-1:0] cap_val(input logic [ADDR_W-1:0] s,
                                               input logic [DATA_W-1:0] d);
    return is_zero(s) ? '0 : d;
  endfunction

  always_comb begin
    state_nx = state;
    rq_nx    = rq;
    op_a_nx  = op_a;
    op_b_nx  = op_b;
    case (state)
      IDLE: if (bus.req_valid) begin
        rq_nx = '{rd_a: bus.req_rd_a, rd_b: bus.req_rd_b, wr: bus.req_wr,
                  sel_a: bus.req_sel_a, sel_b: bus.req_sel_b, sel_w: bus.req_sel_w,
                  wdata: bus.req_wdata};
        op_a_nx = '0;
        op_b_nx = '0;
        if (bus.req_rd_a)      state_nx = RD_A;
        else if (bus.req_rd_b) state_nx = RD_B;
        else if (bus.req_wr)   state_nx = WR;
        else                   state_nx = RESP;
      end
      RD_A: state_nx = rq.rd_b ? RD_B : CAP;
      RD_B: begin
        // Read A's data appears on data_out during the RD_B slot.
        if (rq.rd_a) op_a_nx = cap_val(rq.sel_a, bus.mem_data_out);
        state_nx = CAP;
      end
      CAP: begin
        if (rq.rd_b) op_b_nx = cap_val(rq.sel_b, bus.mem_data_out);
        else         op_a_nx = cap_val(rq.sel_a, bus.mem_data_out);
        state_nx = rq.wr ? WR : RESP;
      end
      WR:   state_nx = RESP;
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes for the state being entered, so the port pins come straight from flops.
  // A suppressed register-0 access keeps its slot but looks like an idle port.
  always_comb begin
    en_nx  = 1'b0;
    rw_nx  = 1'b0;
    sel_nx = '0;
    din_nx = '0;
    case (state_nx)
      RD_A: if (!is_zero(rq_nx.sel_a)) begin
        en_nx  = 1'b1;
        sel_nx = rq_nx.sel_a;
      end
      RD_B: if (!is_zero(rq_nx.sel_b)) begin
        en_nx  = 1'b1;
        sel_nx = rq_nx.sel_b;
      end
      WR: if (!is_zero(rq_nx.sel_w)) begin
        en_nx  = 1'b1;
        rw_nx  = 1'b1;
        sel_nx = rq_nx.sel_w;
        din_nx = rq_nx.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rq         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b0;
      mem_sel    <= '0;
      mem_din    <= '0;
    end else begin
      state      <= state_nx;
      rq         <= rq_nx;
      op_a       <= op_a_nx;
      op_b       <= op_b_nx;
      rsp_valid  <= (state_nx == RESP);
      mem_enable <= en_nx;
      mem_rw     <= rw_nx;
      mem_sel    <= sel_nx;
      mem_din    <= din_nx;
    end
  end

  assign bus.req_ready      = (state == IDLE) && !rst;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_op_a       = op_a;
  assign bus.rsp_op_b       = op_b;
  assign bus.mem_enable     = mem_enable;
  assign bus.mem_read_write = mem_rw;
  assign bus.mem_sel        = mem_sel;
  assign bus.mem_data_in    = mem_din;

endmodule

// File: tb/tb_reg_access_seq.sv
// Directed bench for reg_access_seq against a 32x32 registered-read register memory model.
module tb_reg_access_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   wr_pulses = 0;
  int   en_cnt = 0;
  int   lat;
  int   en_base;
  int   wr_base;

  logic [31:0] mem [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  reg_access_seq_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_access_seq #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory model with a synchronous backdoor preload port; also tallies strobes.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_enable) begin
      if (bus.mem_read_write) mem[bus.mem_sel] <= bus.mem_data_in;
      else                    bus.mem_data_out <= mem[bus.mem_sel];
    end
    if (bus.mem_enable) en_cnt++;
    if (bus.mem_enable && bus.mem_read_write) wr_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic send(input logic ra, input logic rb, input logic w,
                      input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] sw,
                      input logic [31:0] wd);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin step(); n++; end
    chk("req_ready_before_send", {31'd0, bus.req_ready}, 32'd1);
    bus.req_rd_a = ra; bus.req_rd_b = rb; bus.req_wr = w;
    bus.req_sel_a = sa; bus.req_sel_b = sb; bus.req_sel_w = sw; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  // Called right after the accept edge; lat counts cycles until rsp_valid is first seen.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!bus.rsp_valid && l < 20) begin step(); l++; end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_rd_a = 1'b0; bus.req_rd_b = 1'b0; bus.req_wr = 1'b0;
    bus.req_sel_a = '0; bus.req_sel_b = '0; bus.req_sel_w = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.mem_data_out = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    step(); step();

    // Reset state
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mem_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_op_a", bus.rsp_op_a, 32'd0);
    chk("rst_mem_sel", {27'd0, bus.mem_sel}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Reset while in RD_B of a read/read/write transaction
    send(1, 1, 1, 5'd1, 5'd2, 5'd4, 32'h0BAD_0BAD);
    step();
    chk("rdb_enable", {31'd0, bus.mem_enable}, 32'd1);
    chk("rdb_sel", {27'd0, bus.mem_sel}, 32'd2);
    rst = 1'b1;
    step();
    chk("abort_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("abort_req_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    step(); step();
    chk("abort_no_write", wr_pulses, 32'd0);
    chk("abort_mem4", mem[4], 32'd0);

    // Write-only
    send(0, 0, 1, 5'd0, 5'd0, 5'd7, 32'hDEADBEEF);
    chk("wo_enable", {31'd0, bus.mem_enable}, 32'd1);
    chk("wo_rw", {31'd0, bus.mem_read_write}, 32'd1);
    chk("wo_sel", {27'd0, bus.mem_sel}, 32'd7);
    chk("wo_data", bus.mem_data_in, 32'hDEADBEEF);
    chk("wo_rsp_early", {31'd0, bus.rsp_valid}, 32'd0);
    step();
    chk("wo_rsp_valid_lat2", {31'd0, bus.rsp_valid}, 32'd1);
    chk("wo_enable_off", {31'd0, bus.mem_enable}, 32'd0);
    chk("wo_one_pulse", wr_pulses, 32'd1);
    chk("wo_mem7", mem[7], 32'hDEADBEEF);
    finish_rsp();
    chk("wo_idle_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Read A, read B, write same register as A
    preload(5'd3, 32'h11);
    preload(5'd9, 32'h22);
    send(1, 1, 1, 5'd3, 5'd9, 5'd3, 32'h33);
    wait_rsp(lat);
    chk("rrw_latency", lat, 32'd5);
    chk("rrw_op_a", bus.rsp_op_a, 32'h11);
    chk("rrw_op_b", bus.rsp_op_b, 32'h22);
    chk("rrw_mem3", mem[3], 32'h33);
    finish_rsp();
    send(1, 0, 0, 5'd3, 5'd0, 5'd0, 32'h0);
    wait_rsp(lat);
    chk("ra_latency", lat, 32'd3);
    chk("ra_op_a", bus.rsp_op_a, 32'h33);
    chk("ra_op_b", bus.rsp_op_b, 32'h0);
    finish_rsp();

    // Read B only
    preload(5'd5, 32'hA5A5A5A5);
    send(0, 1, 0, 5'd0, 5'd5, 5'd0, 32'h0);
    wait_rsp(lat);
    chk("rb_latency", lat, 32'd3);
    chk("rb_op_b", bus.rsp_op_b, 32'hA5A5A5A5);
    chk("rb_op_a", bus.rsp_op_a, 32'h0);
    finish_rsp();

    // No-op request
    send(0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0);
    wait_rsp(lat);
    chk("noop_latency", lat, 32'd1);
    finish_rsp();

    // Register 0: reads as zero, write suppressed, no strobes, latency unchanged
    preload(5'd0, 32'hFFFFFFFF);
    en_base = en_cnt;
    wr_base = wr_pulses;
    send(1, 0, 1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    wait_rsp(lat);
    chk("z_latency", lat, 32'd4);
    chk("z_op_a", bus.rsp_op_a, 32'h0);
    finish_rsp();
    chk("z_no_enable", en_cnt - en_base, 32'd0);
    chk("z_no_write", wr_pulses - wr_base, 32'd0);
    chk("z_mem0", mem[0], 32'hFFFFFFFF);

    // Response back-pressure; requests in RESP are ignored
    send(1, 0, 0, 5'd3, 5'd0, 5'd0, 32'h0);
    wait_rsp(lat);
    chk("bp_latency", lat, 32'd3);
    wr_base = wr_pulses;
    bus.req_rd_a = 1'b0; bus.req_rd_b = 1'b0; bus.req_wr = 1'b1;
    bus.req_sel_w = 5'd9; bus.req_wdata = 32'hBAD0BAD0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = (i % 2 == 0);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_op_a", bus.rsp_op_a, 32'h33);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      step();
    end
    bus.req_valid = 1'b0;
    finish_rsp();
    chk("bp_release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_release_req_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    chk("bp_not_accepted", {31'd0, bus.mem_enable}, 32'd0);
    chk("bp_no_write", wr_pulses - wr_base, 32'd0);
    chk("bp_mem9", mem[9], 32'h22);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/reg_access_seq.md
Name: reg_access_seq

Overview:
- Requester-side sequencer for the 32x32 single-port register memory (sel / read_write / enable / data_in / data_out, reads registered on clk, write when read_write=1).
- Accepts one operand-fetch/writeback request per transaction: up to two reads (A, B), then an optional write.
- Drives the memory port cycle by cycle and returns the captured operands through a valid/ready response.
- Sits between the decode/execute logic and the register memory.

Parameters:
- DATA_W, 32, data width of the memory and operands.
- ADDR_W, 5, register select width.
- ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are suppressed.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_rd_a  input  1  perform read A.
- req_rd_b  input  1  perform read B.
- req_wr  input  1  perform write.
- req_sel_a  input  ADDR_W  read A register.
- req_sel_b  input  ADDR_W  read B register.
- req_sel_w  input  ADDR_W  write register.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  operands valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_op_a  output  DATA_W  read A result.
- rsp_op_b  output  DATA_W  read B result.
- mem_sel  output  ADDR_W  to memory sel.
- mem_data_in  output  DATA_W  to memory data_in.
- mem_read_write  output  1  0 = read, 1 = write.
- mem_enable  output  1  memory access strobe.
- mem_data_out  input  DATA_W  from memory data_out.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset (rst sampled high at an edge):
  - state goes to IDLE.
  - rsp_op_a, rsp_op_b, and all latched request fields are cleared to 0.
  - rsp_valid=0, mem_enable=0, mem_read_write=0, mem_sel=0, mem_data_in=0.
  - req_ready=0 while rst is high.
- Outputs: the mem_* outputs are Moore-decoded from the registered state and latched fields. Outside an access, mem_sel=0 and mem_data_in=0.
- States: IDLE, RD_A, RD_B, CAP, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields and clear op_a and op_b.
  - Next state: RD_A if rd_a; else RD_B if rd_b; else WR if wr; else RESP.
- RD_A:
  - Drive mem_enable=1, read_write=0, sel=sel_a.
  - Next state: RD_B if rd_b, else CAP.
- RD_B:
  - Drive mem_enable=1, read_write=0, sel=sel_b.
  - If rd_a, capture mem_data_out into op_a at the end of the cycle.
  - Next state: CAP.
- CAP:
  - mem_enable=0.
  - Capture mem_data_out into op_b if rd_b, else into op_a.
  - Next state: WR if wr, else RESP.
- WR:
  - Drive mem_enable=1, read_write=1, sel=sel_w, data_in=wdata.
  - Next state: RESP.
- RESP:
  - rsp_valid=1; rsp_op_a and rsp_op_b are stable.
  - Hold until rsp_ready; then go to IDLE with rsp_valid low on the next cycle.
- Unrequested operands return 0.
- Ordering: reads always precede the write. Reading the register being written returns the old value.
- ZERO_REG=1:
  - A read of sel 0 keeps its state slot but drives mem_enable=0, and the captured value is forced to 0.
  - A write to sel 0 keeps the WR slot with mem_enable=0.
  - Latency is therefore unchanged.
- Latency, counted from the request-accept edge to the first cycle with rsp_valid high:
  - rd_a+rd_b+wr: 5 cycles.
  - rd_a+rd_b: 4 cycles.
  - Single read: 3 cycles.
  - Write only: 2 cycles.
  - No-op (no flags set): 1 cycle.
- Throughput: there is no overlap; a new request is accepted only in IDLE.
- rsp_ready held high in RESP gives a minimum of 1 IDLE cycle between transactions.
- Reset mid-operation aborts the transaction. A write not yet in WR is never issued, a write in WR at the reset edge has already completed, and no response is produced.
- req_* signals are ignored outside IDLE.

Test Plan:
- Reset during RD_B with rd_a, rd_b, wr set -> the next cycle is IDLE with mem_enable=0 and rsp_valid=0; no write pulse ever appears; req_ready=1 once rst is low.
- Write-only request, sel_w=7, wdata=0xDEADBEEF -> mem_enable=1, read_write=1, sel=7, data_in=0xDEADBEEF for exactly one cycle; rsp_valid rises 2 cycles after accept.
- Preload reg3=0x11, reg9=0x22; request rd_a (sel 3), rd_b (sel 9), wr (sel 3, data 0x33) -> rsp_op_a=0x11, rsp_op_b=0x22, rsp_valid after 5 cycles; a following rd_a on 3 returns 0x33.
- rd_b only, sel_b=5 holding 0xA5A5A5A5 -> rsp_op_b=0xA5A5A5A5, rsp_op_a=0, latency 3.
- ZERO_REG=1, reg0 preloaded via backdoor to 0xFFFFFFFF; request rd_a sel 0 plus wr sel 0 -> rsp_op_a=0, mem_enable stays 0 throughout, reg0 is unchanged.
- Hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid and operands stay stable, req_ready=0, and req_valid pulses in that window are not accepted.
